setup_stim_gen: RTL and testbench

- Synthesizable launcher that drives a WIDTH-bit data vector and a WIDTH-bit strobe vector with a programmed setup margin and hold time, counted in `clk` cycles.
- It is the driving end of the vector setup/hold check interface: its `d_out`/`strb_out` feed a timing-checked capture block (`d`/`clk` pair) on the bench or in the design.
- It can place data-to-strobe spacing deliberately inside or outside a checker's setup window, including zero-margin (simultaneous) launches.

---
 rtl/setup_stim_pkg.sv | 13 +
 rtl/stim_down_cnt.sv | 27 ++
 rtl/setup_stim_gen.sv | 135 +++++++++++++
 tb/tb_setup_stim_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/setup_stim_pkg.sv
// Shared types and default sizes for the setup/hold stimulus launcher.
package setup_stim_pkg;

    localparam int unsigned DEF_WIDTH = 3;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2
    } stim_state_e;

endpackage

// File: rtl/stim_down_cnt.sv
// Loadable down counter shared by the setup and hold phases; saturates at zero.
module stim_down_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero_c
);

    // Load takes priority; decrement stops at zero so the count never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/setup_stim_gen.sv
// Launches a data vector, then toggles the masked strobe bits after a
// programmed setup margin and holds them active for a programmed time.
module setup_stim_gen
    import setup_stim_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter logic        STRB_IDLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] strb_mask,
    input  logic [CNT_W-1:0] setup_cyc,
    input  logic [CNT_W-1:0] hold_cyc,
    output logic [WIDTH-1:0] d_out,
    output logic [WIDTH-1:0] strb_out,
    output logic             busy,
    output logic             done,
    output logic             drop
);

    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{STRB_IDLE}};

    stim_state_e      state, state_nxt;
    logic [WIDTH-1:0] mask_q, mask_nxt;
    logic [CNT_W-1:0] hold_q, hold_nxt;
    logic [WIDTH-1:0] d_nxt, strb_nxt;
    logic             busy_nxt, done_nxt, drop_nxt;
    logic             cnt_load, cnt_dec, cnt_zero_c;
    logic [CNT_W-1:0] cnt_val, cnt;

    // A hold of zero cycles is stretched to one so the strobe always pulses.
    function automatic logic [CNT_W-1:0] hold_load(input logic [CNT_W-1:0] h);
        return (h == '0) ? '0 : h - CNT_W'(1);
    endfunction

    stim_down_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero_c   (cnt_zero_c)
    );

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mask_q   <= '0;
            hold_q   <= '0;
            d_out    <= '0;
            strb_out <= IDLE_VEC;
            busy     <= 1'b0;
            done     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            state    <= state_nxt;
            mask_q   <= mask_nxt;
            hold_q   <= hold_nxt;
            d_out    <= d_nxt;
            strb_out <= strb_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            drop     <= drop_nxt;
        end
    end

    // Next-state, counter control and next output values.
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask_q;
        hold_nxt  = hold_q;
        d_nxt     = d_out;
        strb_nxt  = strb_out;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        drop_nxt  = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        cnt_dec   = 1'b0;

        // Requests are only taken in IDLE; anything else is reported and lost.
        if (start && (state != IDLE)) begin
            drop_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (start) begin
                    d_nxt    = data_in;
                    mask_nxt = strb_mask;
                    hold_nxt = hold_cyc;
                    busy_nxt = 1'b1;
                    cnt_load = 1'b1;
                    if (setup_cyc == '0) begin
                        strb_nxt  = IDLE_VEC ^ strb_mask;
                        state_nxt = HOLD;
                        cnt_val   = hold_load(hold_cyc);
                    end else begin
                        state_nxt = SETUP;
                        cnt_val   = setup_cyc - CNT_W'(1);
                    end
                end
            end
            SETUP: begin
                if (cnt_zero_c) begin
                    strb_nxt  = IDLE_VEC ^ mask_q;
                    state_nxt = HOLD;
                    cnt_load  = 1'b1;
                    cnt_val   = hold_load(hold_q);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_zero_c) begin
                    strb_nxt  = IDLE_VEC;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_setup_stim_gen.sv
// Scoreboard bench for setup_stim_gen: the driver predicts each request's
// launch/strobe/done timing from plain cycle arithmetic, the monitor checks.
module tb_setup_stim_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    always #5 clk = ~clk;

    // Instance with posedge strobes (idle low).
    logic       start;
    logic [2:0] data_in, strb_mask;
    logic [7:0] setup_cyc, hold_cyc;
    logic [2:0] d_out, strb_out;
    logic       busy, done, drop;

    // Instance with negedge strobes (idle high).
    logic       start1;
    logic [2:0] data1, mask1;
    logic [7:0] setup1, hold1;
    logic [2:0] d_out1, strb_out1;
    logic       busy1, done1, drop1;

    setup_stim_gen dut0 (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .strb_mask(strb_mask), .setup_cyc(setup_cyc), .hold_cyc(hold_cyc),
        .d_out(d_out), .strb_out(strb_out), .busy(busy), .done(done), .drop(drop)
    );

    setup_stim_gen #(.STRB_IDLE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .data_in(data1),
        .strb_mask(mask1), .setup_cyc(setup1), .hold_cyc(hold1),
        .d_out(d_out1), .strb_out(strb_out1), .busy(busy1), .done(done1), .drop(drop1)
    );

    // Edge index: at a negedge, cyc names the posedge just passed.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         e;
        logic [2:0] d;
        logic [2:0] mask;
        int         s;
        int         h;
    } req_t;

    req_t acc_q[$];
    req_t done_q[$];
    int   drop_q[$];
    int   free_at = 0;
    int   cur_lo = -1, cur_hi = -2, prv_lo = -1, prv_hi = -2;
    int   act_cyc = -1;
    logic [2:0] act_val = '0;
    logic [2:0] prev_strb = '0;
    req_t mon_r;
    int   mon_drop;
    logic busy_exp;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Issue one request on the next edge and record what the model predicts.
    task automatic drive_start(input logic [2:0] d, input logic [2:0] m, input int s, input int h);
        req_t r;
        int   n;
        int   hh;
        @(negedge clk);
        start     = 1'b1;
        data_in   = d;
        strb_mask = m;
        setup_cyc = 8'(s);
        hold_cyc  = 8'(h);
        n  = cyc + 1;
        hh = (h == 0) ? 1 : h;
        if (n >= free_at) begin
            r = '{n, d, m, s, hh};
            acc_q.push_back(r);
            done_q.push_back(r);
            free_at = n + s + hh + 1;
            prv_lo  = cur_lo;
            prv_hi  = cur_hi;
            cur_lo  = n;
            cur_hi  = n + s + hh;
        end else begin
            drop_q.push_back(n);
        end
        @(negedge clk);
        start     = 1'b0;
        data_in   = 3'($urandom);
        strb_mask = 3'($urandom);
        setup_cyc = 8'($urandom);
        hold_cyc  = 8'($urandom);
    endtask

    // Wait for every outstanding prediction to be consumed, with a cycle budget.
    task automatic drain();
        int budget = 600;
        while (((done_q.size() != 0) || (drop_q.size() != 0) || (cyc < free_at)) && (budget > 0)) begin
            @(negedge clk);
            budget--;
        end
        n_tests++;
        if (budget == 0) begin
            n_fail++;
            $display("FAIL drain_timeout at edge %0d: pending done %0d drop %0d", cyc, done_q.size(), drop_q.size());
        end
    endtask

    // Monitor: compares DUT outputs against the predictions as they appear.
    always @(negedge clk) begin
        if (!rst) begin
            busy_exp = ((cyc >= cur_lo) && (cyc <= cur_hi)) || ((cyc >= prv_lo) && (cyc <= prv_hi));
            chk("busy", 32'(busy), 32'(busy_exp));

            if ((acc_q.size() != 0) && (acc_q[0].e <= cyc)) begin
                mon_r = acc_q.pop_front();
                chk("launch_edge", 32'(cyc), 32'(mon_r.e));
                chk("d_out_launch", 32'(d_out), 32'(mon_r.d));
            end

            if ((strb_out != 3'b000) && (prev_strb == 3'b000)) begin
                act_cyc = cyc;
                act_val = strb_out;
            end
            prev_strb = strb_out;

            if (done) begin
                if (done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done at edge %0d: got 1 expected 0", cyc);
                end else begin
                    mon_r = done_q.pop_front();
                    chk("done_edge", 32'(cyc), 32'(mon_r.e + mon_r.s + mon_r.h));
                    chk("d_out_held", 32'(d_out), 32'(mon_r.d));
                    chk("strb_idle_at_done", 32'(strb_out), 32'(0));
                    if (mon_r.mask != 3'b000) begin
                        chk("strb_edge", 32'(act_cyc), 32'(mon_r.e + mon_r.s));
                        chk("strb_value", 32'(act_val), 32'(mon_r.mask));
                    end else begin
                        chk("strb_masked", 32'(act_cyc), 32'(-1));
                    end
                end
                act_cyc = -1;
            end

            if (drop) begin
                if (drop_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_drop at edge %0d: got 1 expected 0", cyc);
                end else begin
                    mon_drop = drop_q.pop_front();
                    chk("drop_edge", 32'(cyc), 32'(mon_drop));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog at edge %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; data_in = '0; strb_mask = '0; setup_cyc = '0; hold_cyc = '0;
        start1 = 0; data1 = '0; mask1 = '0; setup1 = '0; hold1 = '0;

        // Reset values.
        #12;
        chk("rst_d_out", 32'(d_out), 32'(0));
        chk("rst_strb", 32'(strb_out), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_drop", 32'(drop), 32'(0));
        chk("rst_strb_idle_hi", 32'(strb_out1), 32'(3'b111));
        @(negedge clk);
        rst = 1'b0;

        // Setup margin of 10, hold 2, then a colliding start three edges later.
        drive_start(3'b011, 3'b010, 10, 2);
        @(negedge clk);
        drive_start(3'b101, 3'b111, 5, 1);

        // Back-to-back: restart on the earliest legal edge.
        while (cyc + 2 < free_at) @(negedge clk);
        drive_start(3'b110, 3'b101, 0, 3);
        drain();

        // Maximum setup count.
        drive_start(3'b001, 3'b100, 255, 1);
        drain();

        // Randomized requests, many landing while busy.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                while (cyc + 2 < free_at) @(negedge clk);
            end
            drive_start(3'($urandom), 3'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 4)));
        end
        drain();

        // Zero-margin launch on the idle-high instance.
        @(negedge clk);
        chk("z_strb_idle", 32'(strb_out1), 32'(3'b111));
        start1 = 1'b1; data1 = 3'b111; mask1 = 3'b111; setup1 = 8'd0; hold1 = 8'd0;
        @(negedge clk);
        start1 = 1'b0; data1 = 3'b000; mask1 = 3'b000; setup1 = 8'd9; hold1 = 8'd9;
        chk("z_d_out", 32'(d_out1), 32'(3'b111));
        chk("z_strb_active", 32'(strb_out1), 32'(3'b000));
        chk("z_busy", 32'(busy1), 32'(1));
        chk("z_done_early", 32'(done1), 32'(0));
        @(negedge clk);
        chk("z_strb_release", 32'(strb_out1), 32'(3'b111));
        chk("z_done", 32'(done1), 32'(1));
        chk("z_busy_done", 32'(busy1), 32'(1));
        @(negedge clk);
        chk("z_busy_clear", 32'(busy1), 32'(0));
        chk("z_done_clear", 32'(done1), 32'(0));
        chk("z_d_out_held", 32'(d_out1), 32'(3'b111));
        chk("z_no_drop", 32'(drop1), 32'(0));

        // Asynchronous reset in the middle of a setup phase.
        drive_start(3'b010, 3'b011, 10, 2);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_d_out", 32'(d_out), 32'(0));
        chk("arst_strb", 32'(strb_out), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        acc_q.delete();
        done_q.delete();
        drop_q.delete();
        free_at = 0;
        cur_lo = -1; cur_hi = -2; prv_lo = -1; prv_hi = -2;
        act_cyc = -1;
        prev_strb = '0;
        @(negedge clk);
        chk("arst_held_strb", 32'(strb_out), 32'(0));
        rst = 1'b0;

        // Normal operation resumes after reset.
        drive_start(3'b100, 3'b001, 2, 1);
        drain();

        chk("queues_empty", 32'(acc_q.size() + done_q.size() + drop_q.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
